// File: rtl/reg_write_master.sv
// -----------------------------------------------------------------------------
// reg_write_master
//
// Turns a serial byte stream from the UART receiver into single-cycle register
// write strobes on the addr/data/en bus. It drives the parameter-storage blocks
// (the interrupter and its peers) that sit on that bus.
//
// Frame (4 bytes, one rx_valid strobe each):
//   SYNC_BYTE, ADDR_B, DATA_B, CSUM   with   CSUM == SYNC_BYTE ^ ADDR_B ^ DATA_B
//
// A frame is written only if the checksum matches, ADDR_B <= ADDR_MAX and
// DATA_B <= PAR_MAX_VAL. Bytes outside a frame that are not SYNC_BYTE are
// dropped silently. A frame that stalls for TIMEOUT_CYC cycles between bytes
// is abandoned and counted as rejected.
//
// Ports:
//   clk        in   1   system clock, all logic on posedge
//   rst        in   1   synchronous reset, active high
//   rx_byte    in   8   received byte, qualified by rx_valid
//   rx_valid   in   1   one-cycle strobe per byte (no backpressure)
//   addr       out  AW  write address, holds until the next accepted frame
//   data       out  DW  write data, holds until the next accepted frame
//   en         out  1   write strobe, one cycle per accepted frame
//   frame_err  out  1   one-cycle pulse per rejected or timed-out frame
//   err_cnt    out  8   saturating count of rejected frames
// -----------------------------------------------------------------------------
module reg_write_master #(
    parameter int          CLK_MHZ     = 100,      // documentation only
    parameter int          PAR_MAX_VAL = 255,      // must fit in one byte
    parameter int          ADDR_MAX    = 4,        // must fit in one byte
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 100_000,  // must be >= 2
    localparam int         DW          = $clog2(PAR_MAX_VAL + 1),
    localparam int         AW          = $clog2(ADDR_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_byte,
    input  logic          rx_valid,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          en,
    output logic          frame_err,
    output logic [7:0]    err_cnt
);

    // Timeout counter only has to reach TIMEOUT_CYC-1.
    localparam int            TW        = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    ADDR_MAXB = 8'(ADDR_MAX);
    localparam logic [7:0]    DATA_MAXB = 8'(PAR_MAX_VAL);

    // Elaboration-time sanity checks on the parameter set.
    if (CLK_MHZ < 1) begin : g_bad_clk
        $error("reg_write_master: CLK_MHZ must be positive");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_tmo
        $error("reg_write_master: TIMEOUT_CYC must be at least 2");
    end
    if (PAR_MAX_VAL > 255 || ADDR_MAX > 255) begin : g_bad_range
        $error("reg_write_master: address and data limits must fit in a byte");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CSUM
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [7:0]    addr_sh;      // ADDR_B of the frame in flight
    logic [7:0]    data_sh;      // DATA_B of the frame in flight
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_nxt;

    logic          tmo_hit;      // frame stalled, no byte this cycle
    logic          frame_ok;     // full validity of the frame closed by CSUM
    logic          accept;
    logic          reject;

    // Range checks use the full received byte so an out-of-range address is
    // not aliased into range by truncation to AW bits.
    assign frame_ok = (rx_byte == (SYNC_BYTE ^ addr_sh ^ data_sh))
                   && (addr_sh <= ADDR_MAXB)
                   && (data_sh <= DATA_MAXB);

    // A byte arriving on the timeout cycle wins, hence the !rx_valid term.
    assign tmo_hit = (state != S_IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);

    // -------------------------------------------------------------------------
    // Next-state and strobe decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case can leave one unassigned and infer a latch.
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    state_nxt = S_DATA;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                    reject    = 1'b1;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    state_nxt = S_CSUM;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                    reject    = 1'b1;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    state_nxt = S_IDLE;
                    accept    = frame_ok;
                    reject    = !frame_ok;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                    reject    = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Counter runs only while a frame is open and restarts on every byte.
    always_comb begin
        tmo_nxt = tmo_cnt + TW'(1);
        if (rx_valid || (state == S_IDLE) || tmo_hit) begin
            tmo_nxt = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Bus outputs, error reporting, timeout counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            data      <= '0;
            en        <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            en        <= accept;
            frame_err <= reject;
            tmo_cnt   <= tmo_nxt;
            if (accept) begin
                addr <= addr_sh[AW-1:0];
                data <= data_sh[DW-1:0];
            end
            if (reject && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Shadow registers
    // -------------------------------------------------------------------------
    // NOTE: the shadows are deliberately left out of reset; they are always
    // overwritten by ADDR_B/DATA_B before the CSUM byte can consume them.
    always_ff @(posedge clk) begin
        if (rx_valid && (state == S_ADDR)) begin
            addr_sh <= rx_byte;
        end
        if (rx_valid && (state == S_DATA)) begin
            data_sh <= rx_byte;
        end
    end

endmodule

// File: tb/tb_reg_write_master.sv
// -----------------------------------------------------------------------------
// Bench for reg_write_master. Frames are driven one byte per cycle on the
// falling edge; outputs are sampled on the falling edge right after the CSUM
// byte has been clocked in, which is where the one-cycle write latency lands.
// A short TIMEOUT_CYC keeps the stall scenarios quick.
// -----------------------------------------------------------------------------
module tb_reg_write_master;

    localparam int         TMO  = 40;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic [2:0] addr;
    logic [7:0] data;
    logic       en;
    logic       frame_err;
    logic [7:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int en_pulses  = 0;
    int err_pulses = 0;

    reg_write_master #(
        .CLK_MHZ     (100),
        .PAR_MAX_VAL (255),
        .ADDR_MAX    (4),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .addr      (addr),
        .data      (data),
        .en        (en),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters: read at the rising edge, i.e. the value of the cycle
    // that is just ending.
    always @(posedge clk) begin
        if (en)        en_pulses  = en_pulses + 1;
        if (frame_err) err_pulses = err_pulses + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic [31:0] frame;     // SYNC, ADDR_B, DATA_B, CSUM from MSB down
        logic        exp_en;
        logic [2:0]  exp_addr;
        logic [7:0]  exp_data;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one byte for exactly one rising edge; rx_valid stays high so the
    // next byte can follow with no gap.
    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] f);
        for (int i = 3; i >= 0; i--) begin
            send_byte(f[8*i +: 8]);
        end
    endtask

    task automatic go_idle();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    // Bus state one cycle after the CSUM strobe.
    task automatic check_result(input string name, input logic exp_en,
                                input logic [2:0] exp_addr, input logic [7:0] exp_data,
                                input logic [7:0] exp_cnt);
        check({name, ".en"},        en,        exp_en);
        check({name, ".frame_err"}, frame_err, !exp_en);
        check({name, ".addr"},      addr,      exp_addr);
        check({name, ".data"},      data,      exp_data);
        check({name, ".err_cnt"},   err_cnt,   exp_cnt);
    endtask

    // Strobes must drop after exactly one cycle.
    task automatic check_quiet(input string name);
        go_idle();
        @(negedge clk);
        check({name, ".en_off"},  en,        1'b0);
        check({name, ".err_off"}, frame_err, 1'b0);
    endtask

    initial begin
        int k;
        int e0;
        int p0;

        vecs[0] = '{"ok_addr_max",  32'hA5043C9D, 1'b1, 3'd4, 8'h3C, 8'd0};
        vecs[1] = '{"bad_csum",     32'hA5021000, 1'b0, 3'd4, 8'h3C, 8'd1};
        vecs[2] = '{"addr_7",       32'hA50711B3, 1'b0, 3'd4, 8'h3C, 8'd2};
        vecs[3] = '{"addr_5",       32'hA50500A0, 1'b0, 3'd4, 8'h3C, 8'd3};
        vecs[4] = '{"sync_as_data", 32'hA502A502, 1'b1, 3'd2, 8'hA5, 8'd3};
        vecs[5] = '{"zero_data",    32'hA50000A5, 1'b1, 3'd0, 8'h00, 8'd3};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("reset.addr",      addr,      3'd0);
        check("reset.data",      data,      8'h00);
        check("reset.en",        en,        1'b0);
        check("reset.frame_err", frame_err, 1'b0);
        check("reset.err_cnt",   err_cnt,   8'd0);
        rst = 1'b0;
        @(negedge clk);

        // ---- table of complete frames ----
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].frame);
            check_result(vecs[i].name, vecs[i].exp_en, vecs[i].exp_addr,
                         vecs[i].exp_data, vecs[i].exp_cnt);
            check_quiet(vecs[i].name);
        end

        // ---- inter-byte timeout: exactly TMO silent cycles ----
        send_byte(SYNC);
        send_byte(8'h01);
        go_idle();
        k = 0;
        while (!frame_err && k < TMO + 10) begin
            @(negedge clk);
            k++;
        end
        check("tmo.latency",   k,       TMO);
        check("tmo.err_cnt",   err_cnt, 8'd4);
        check("tmo.en",        en,      1'b0);
        check_quiet("tmo");
        send_frame(32'hA501FF5B);
        check_result("after_tmo", 1'b1, 3'd1, 8'hFF, 8'd4);
        check_quiet("after_tmo");

        // ---- byte arriving on the timeout cycle wins ----
        p0 = err_pulses;
        send_byte(SYNC);
        go_idle();
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'hB7);
        check_result("tmo_race", 1'b1, 3'd2, 8'h10, 8'd4);
        check_quiet("tmo_race");
        check("tmo_race.no_err_pulse", err_pulses - p0, 0);

        // ---- garbage, then back-to-back frames ----
        p0 = err_pulses;
        e0 = en_pulses;
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h77);
        send_frame(32'hA5038026);
        check_result("b2b_first", 1'b1, 3'd3, 8'h80, 8'd4);
        send_frame(32'hA50001A4);
        check_result("b2b_second", 1'b1, 3'd0, 8'h01, 8'd4);
        check_quiet("b2b");
        check("b2b.en_pulses",   en_pulses - e0,  2);
        check("b2b.garbage_err", err_pulses - p0, 0);

        // ---- reset in the middle of a frame ----
        send_byte(SYNC);
        send_byte(8'h02);
        go_idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst.addr",      addr,      3'd0);
        check("midrst.data",      data,      8'h00);
        check("midrst.en",        en,        1'b0);
        check("midrst.frame_err", frame_err, 1'b0);
        check("midrst.err_cnt",   err_cnt,   8'd0);
        rst = 1'b0;
        @(negedge clk);
        e0 = en_pulses;
        send_frame(32'hA50205A2);
        check_result("after_rst", 1'b1, 3'd2, 8'h05, 8'd0);
        check_quiet("after_rst");
        check("after_rst.en_pulses", en_pulses - e0, 1);

        // ---- error counter saturation ----
        for (int i = 0; i < 256; i++) begin
            send_frame(32'hA5021000);
            if (i == 253) begin
                check("sat.cnt_254", err_cnt, 8'd254);
            end
            if (i == 255) begin
                check_result("sat.final", 1'b0, 3'd2, 8'h05, 8'd255);
            end
            go_idle();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_master.md
Name: reg_write_master

Overview:
- Command decoder that turns a serial byte stream (from the UART receiver) into single-cycle register-write strobes on the addr/data/en bus.
- It is the initiator side of the bus that the interrupter and other parameter-storage blocks respond to.
- Frames are validated by a sync byte, a range-checked address and an XOR checksum; stalled frames are dropped by an inter-byte timeout.

Parameters:
- CLK_MHZ, 100: clock frequency in MHz. Documentation only; timeout is in cycles.
- PAR_MAX_VAL, 255: max data value. Data width DW = $clog2(PAR_MAX_VAL+1) (8 by default).
- ADDR_MAX, 4: highest valid address. Address width AW = $clog2(ADDR_MAX+1) (3 by default).
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYC, 100_000: max idle cycles between bytes inside a frame.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: synchronous reset, active-high.
- rx_byte, input, 8: received byte; valid only while rx_valid is high.
- rx_valid, input, 1: one-cycle strobe per byte. Block is always ready (no backpressure).
- addr, output, AW: write address, registered.
- data, output, DW: write data, registered.
- en, output, 1: write strobe, high for exactly one cycle per accepted frame.
- frame_err, output, 1: one-cycle pulse on any rejected frame.
- err_cnt, output, 8: saturating count of rejected frames.

Behaviour:
- Reset (rst=1 at a posedge): state=S_IDLE, addr=0, data=0, en=0, frame_err=0, err_cnt=0, timeout counter=0.
  - Applies mid-frame: the partial frame is discarded and not counted as an error.
- Frame format, 4 bytes: SYNC_BYTE, ADDR_B, DATA_B, CSUM.
  - Checksum rule: CSUM == SYNC_BYTE ^ ADDR_B ^ DATA_B.
- State machine, transitions on rx_valid unless noted:
  - S_IDLE:
    - byte == SYNC_BYTE -> S_ADDR.
    - any other byte: ignored, no error.
  - S_ADDR: latch ADDR_B into a shadow register -> S_DATA.
  - S_DATA: latch DATA_B into a shadow register -> S_CSUM.
  - S_CSUM: evaluate and return to S_IDLE.
    - Accept: checksum matches AND ADDR_B <= ADDR_MAX AND DATA_B <= PAR_MAX_VAL.
    - Otherwise: reject.
- Accept path: if CSUM arrives at cycle N:
  - addr/data update from the shadow registers at N+1.
  - en=1 during cycle N+1 only.
  - addr/data then hold until the next accepted frame.
  - Write latency: 1 cycle from the CSUM strobe.
- Reject path: frame_err=1 during cycle N+1; err_cnt increments, saturating at 255. addr, data and en are unchanged.
- Timeout:
  - The counter clears on every rx_valid and in S_IDLE, and increments every cycle in S_ADDR, S_DATA and S_CSUM.
  - When it reaches TIMEOUT_CYC-1 with no rx_valid: -> S_IDLE, frame_err pulse, err_cnt++.
  - If rx_valid coincides with the timeout cycle, the byte wins: it is processed normally and no timeout fires.
- Back-to-back frames: a SYNC_BYTE may arrive in the cycle right after CSUM; it is accepted (the FSM is already in S_IDLE).
- A SYNC_BYTE value seen as ADDR_B, DATA_B or CSUM is treated as ordinary payload (no resync).
- Shadow registers are internal; the bus outputs never show partial frames.
- en and frame_err are never high in the same cycle.

Test Plan:
1. Reset, then bytes A5,04,3C,9D (3C ^ A5 ^ 04 = 9D) -> one cycle after 9D: addr=4, data=8'h3C, en=1 for exactly 1 cycle. frame_err=0, err_cnt=0.
2. Bytes A5,02,10,00 (bad checksum) -> frame_err pulse 1 cycle, err_cnt=1, en never high, addr/data keep previous values.
3. Bytes A5,07,11,B3 (checksum valid, addr 7 > ADDR_MAX) -> rejected: frame_err pulse, err_cnt increments, no en.
4. A5,01 then silence for TIMEOUT_CYC cycles -> return to S_IDLE, frame_err pulse, err_cnt++. Then a full valid frame A5,01,FF,5B -> en, addr=1, data=FF.
5. Garbage 00,13,77, then A5,03,80,26 back-to-back with a second A5,00,01,A4 -> garbage ignored, err_cnt unchanged, two en pulses (addr=3/data=80, then addr=0/data=01).
6. rst asserted after A5,02 mid-frame, then A5,02,05,A2 -> all outputs 0 during reset, err_cnt=0 after reset, single en with addr=2, data=5. Also drive 256 bad frames -> err_cnt saturates at 255.
